soc_system_pio_master: RTL and testbench

SOC_SYSTEM_PIO_MASTER -- requirements
Module: soc_system_pio_master

---
 rtl/soc_system_pio_master_if.sv | 65 ++++++
 rtl/soc_system_pio_master.sv | 168 ++++++++++++++++
 tb/tb_soc_system_pio_master.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_pio_master_if.sv
// Command/response and Avalon-MM host signal bundle for soc_system_pio_master.
//
// master modport : the PIO master block itself (accepts commands, drives the bus)
// slave modport  : the surroundings (command requester plus Avalon-MM responder)
//
// Command side : cmd_valid, cmd_ready, cmd_write, cmd_address, cmd_writedata
// Response side: rsp_valid, rsp_write, rsp_readdata
// Avalon-MM    : address, chipselect, write_n, read_n, writedata, readdata
interface soc_system_pio_master_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_writedata;

  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_readdata;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic              read_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_address,
    input  cmd_writedata,
    input  readdata,
    output cmd_ready,
    output rsp_valid,
    output rsp_write,
    output rsp_readdata,
    output address,
    output chipselect,
    output write_n,
    output read_n,
    output writedata
  );

  modport slave (
    output cmd_valid,
    output cmd_write,
    output cmd_address,
    output cmd_writedata,
    output readdata,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_write,
    input  rsp_readdata,
    input  address,
    input  chipselect,
    input  write_n,
    input  read_n,
    input  writedata
  );

endinterface

// File: rtl/soc_system_pio_master.sv
// Single-outstanding Avalon-MM host that turns a valid/ready command into one
// write or read strobe on a PIO-style responder and reports completion with a
// one-cycle response pulse.
//
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : soc_system_pio_master_if.master
//             cmd_*  command in (valid/ready handshake)
//             rsp_*  one-cycle completion pulse, type, captured read data
//             address/chipselect/write_n/read_n/writedata/readdata Avalon-MM host
//
// Every output comes straight from a register. Write: accept, WR, RESP, IDLE.
// Read: accept, RD, READ_LATENCY cycles of RWAIT, RESP, IDLE.
module soc_system_pio_master #(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1   // legal 0..7
) (
  input logic                     clk,
  input logic                     reset_n,
  soc_system_pio_master_if.master bus
);

  localparam logic [2:0] LatCnt = 3'(READ_LATENCY);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRwait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;          // latched command type
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              chipselect_q, chipselect_d;
  logic              write_n_q, write_n_d;
  logic              read_n_q, read_n_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_readdata_q, rsp_readdata_d;

  logic              to_resp;
  logic              capture;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wr_d           = wr_q;
    address_d      = address_q;
    writedata_d    = writedata_q;
    chipselect_d   = 1'b0;
    write_n_d      = 1'b1;
    read_n_d       = 1'b1;
    rsp_valid_d    = 1'b0;
    rsp_write_d    = rsp_write_q;
    rsp_readdata_d = rsp_readdata_q;
    to_resp        = 1'b0;
    capture        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          wr_d         = bus.cmd_write;
          address_d    = bus.cmd_address;
          chipselect_d = 1'b1;
          if (bus.cmd_write) begin
            // writedata only moves for writes so reads leave the bus data alone
            writedata_d = bus.cmd_writedata;
            write_n_d   = 1'b0;
            state_d     = StWr;
          end else begin
            read_n_d = 1'b0;
            state_d  = StRd;
          end
        end
      end
      StWr: begin
        to_resp = 1'b1;
      end
      StRd: begin
        if (READ_LATENCY == 0) begin
          capture = 1'b1;
          to_resp = 1'b1;
        end else begin
          cnt_d   = LatCnt;
          state_d = StRwait;
        end
      end
      StRwait: begin
        // Counter steps LatCnt..1 across the wait cycles; the edge that would
        // take it to 0 is the one where readdata is valid.
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          capture = 1'b1;
          to_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (to_resp) begin
      state_d     = StResp;
      rsp_valid_d = 1'b1;
      rsp_write_d = wr_q;
    end

    if (capture) begin
      rsp_readdata_d = bus.readdata;
    end

    // Registered ready: high exactly while the machine sits in IDLE.
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      cnt_q          <= 3'd0;
      wr_q           <= 1'b0;
      address_q      <= '0;
      writedata_q    <= '0;
      chipselect_q   <= 1'b0;
      write_n_q      <= 1'b1;
      read_n_q       <= 1'b1;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_readdata_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_q           <= wr_d;
      address_q      <= address_d;
      writedata_q    <= writedata_d;
      chipselect_q   <= chipselect_d;
      write_n_q      <= write_n_d;
      read_n_q       <= read_n_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_write_q    <= rsp_write_d;
      rsp_readdata_q <= rsp_readdata_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_write    = rsp_write_q;
  assign bus.rsp_readdata = rsp_readdata_q;
  assign bus.address      = address_q;
  assign bus.chipselect   = chipselect_q;
  assign bus.write_n      = write_n_q;
  assign bus.read_n       = read_n_q;
  assign bus.writedata    = writedata_q;

endmodule

// File: tb/tb_soc_system_pio_master.sv
// Bench for soc_system_pio_master: four instances (READ_LATENCY 1, 2, 0, 7),
// each on a PIO responder whose readdata is valid only READ_LATENCY cycles
// after the read strobe. Reference: a per-instance register array plus the
// transaction timing rules (write rsp at accept+2, read rsp at accept+2+L).
module tb_soc_system_pio_master;

  localparam int NDUT = 4;

  function automatic int unsigned lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 0;
      default: return 7;
    endcase
  endfunction

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid     [NDUT];
  logic        cmd_write     [NDUT];
  logic [1:0]  cmd_address   [NDUT];
  logic [31:0] cmd_writedata [NDUT];

  logic        obs_ready [NDUT];
  logic        obs_rv    [NDUT];
  logic        obs_rw    [NDUT];
  logic [31:0] obs_rd    [NDUT];
  logic [1:0]  obs_addr  [NDUT];
  logic [31:0] obs_wdata [NDUT];
  logic        obs_cs    [NDUT];
  logic        obs_wn    [NDUT];
  logic        obs_rn    [NDUT];
  logic [31:0] out_port  [NDUT];
  int          wr_cnt    [NDUT];
  int          rd_cnt    [NDUT];
  int          rsp_cnt   [NDUT];
  int          both_cnt  [NDUT];
  logic [1:0]  wr_addr_s [NDUT];
  logic [31:0] wr_data_s [NDUT];
  logic [1:0]  rd_addr_s [NDUT];

  // Reference model
  logic [31:0] mem_m   [NDUT][4];
  logic [31:0] last_rd [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned L = lat_of(g);

    soc_system_pio_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();

    soc_system_pio_master #(
      .ADDR_W      (2),
      .DATA_W      (32),
      .READ_LATENCY(L)
    ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );

    assign bus.cmd_valid     = cmd_valid[g];
    assign bus.cmd_write     = cmd_write[g];
    assign bus.cmd_address   = cmd_address[g];
    assign bus.cmd_writedata = cmd_writedata[g];

    assign obs_ready[g] = bus.cmd_ready;
    assign obs_rv[g]    = bus.rsp_valid;
    assign obs_rw[g]    = bus.rsp_write;
    assign obs_rd[g]    = bus.rsp_readdata;
    assign obs_addr[g]  = bus.address;
    assign obs_wdata[g] = bus.writedata;
    assign obs_cs[g]    = bus.chipselect;
    assign obs_wn[g]    = bus.write_n;
    assign obs_rn[g]    = bus.read_n;

    // PIO responder: addr 1 (direction register) reads 0, others are storage
    logic [31:0] pio_q  [4];
    logic [31:0] pipe_q [8];
    logic [31:0] rd_now;
    logic        stb_wr, stb_rd;
    int wr_c = 0, rd_c = 0, rsp_c = 0, both_c = 0;
    logic [1:0]  wa_s = 2'd0, ra_s = 2'd0;
    logic [31:0] wd_s = 32'd0;

    assign stb_wr = bus.chipselect && !bus.write_n;
    assign stb_rd = bus.chipselect && !bus.read_n;
    // Outside the valid cycle readdata carries junk so a mistimed capture shows
    assign rd_now = stb_rd ? ((bus.address == 2'd1) ? 32'h0 : pio_q[bus.address])
                           : (32'hBAD0_0000 + 32'(cyc));

    if (L == 0) begin : g_l0
      assign bus.readdata = rd_now;
    end else begin : g_ln
      assign bus.readdata = pipe_q[L-1];
    end

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < 4; i++) pio_q[i] <= 32'h0;
      end else if (stb_wr && bus.address != 2'd1) begin
        pio_q[bus.address] <= bus.writedata;
      end
    end

    always @(posedge clk) begin
      pipe_q[0] <= rd_now;
      for (int i = 1; i < 8; i++) pipe_q[i] <= pipe_q[i-1];
      if (stb_wr) begin wr_c <= wr_c + 1; wa_s <= bus.address; wd_s <= bus.writedata; end
      if (stb_rd) begin rd_c <= rd_c + 1; ra_s <= bus.address; end
      if (stb_wr && stb_rd) both_c <= both_c + 1;
      if (bus.rsp_valid) rsp_c <= rsp_c + 1;
    end

    assign out_port[g]  = pio_q[0];
    assign wr_cnt[g]    = wr_c;
    assign rd_cnt[g]    = rd_c;
    assign rsp_cnt[g]   = rsp_c;
    assign both_cnt[g]  = both_c;
    assign wr_addr_s[g] = wa_s;
    assign wr_data_s[g] = wd_s;
    assign rd_addr_s[g] = ra_s;
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++) begin
      last_rd[d] = 32'h0;
      for (int a = 0; a < 4; a++) mem_m[d][a] = 32'h0;
    end
  endtask

  task automatic chk_reset_outs(input int d, input string tag);
    chk(32'(obs_ready[d]), 32'd0, $sformatf("%s_ready_d%0d", tag, d));
    chk(32'(obs_rv[d]),    32'd0, $sformatf("%s_rsp_valid_d%0d", tag, d));
    chk(32'(obs_rw[d]),    32'd0, $sformatf("%s_rsp_write_d%0d", tag, d));
    chk(obs_rd[d],         32'd0, $sformatf("%s_rsp_readdata_d%0d", tag, d));
    chk(32'(obs_addr[d]),  32'd0, $sformatf("%s_address_d%0d", tag, d));
    chk(obs_wdata[d],      32'd0, $sformatf("%s_writedata_d%0d", tag, d));
    chk(32'(obs_cs[d]),    32'd0, $sformatf("%s_chipselect_d%0d", tag, d));
    chk(32'(obs_wn[d]),    32'd1, $sformatf("%s_write_n_d%0d", tag, d));
    chk(32'(obs_rn[d]),    32'd1, $sformatf("%s_read_n_d%0d", tag, d));
  endtask

  // Called and returns at a negedge.
  task automatic do_txn(input int d, input bit wr, input logic [1:0] a, input logic [31:0] wd);
    int acc, n, w0, r0, s0;
    cmd_valid[d] = 1'b1; cmd_write[d] = wr; cmd_address[d] = a; cmd_writedata[d] = wd;
    n = 0;
    while (obs_ready[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      chk(32'(obs_ready[d]), 32'd1, $sformatf("accept_timeout_d%0d", d));
      cmd_valid[d] = 1'b0;
      return;
    end
    acc = cyc; w0 = wr_cnt[d]; r0 = rd_cnt[d]; s0 = rsp_cnt[d];
    @(negedge clk);
    // Scramble the command after accept; the transaction must not notice
    cmd_valid[d] = 1'b0; cmd_write[d] = 1'($urandom);
    cmd_address[d] = 2'($urandom_range(0, 3)); cmd_writedata[d] = $urandom;
    if (wr) begin
      if (a != 2'd1) mem_m[d][a] = wd;
    end else begin
      last_rd[d] = (a == 2'd1) ? 32'h0 : mem_m[d][a];
    end
    n = 0;
    while (obs_rv[d] !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    chk(32'(cyc - acc), wr ? 32'd2 : 32'(2 + lat_of(d)), $sformatf("rsp_latency_d%0d", d));
    chk(32'(obs_rw[d]), 32'(wr), $sformatf("rsp_write_d%0d", d));
    chk(obs_rd[d], last_rd[d], $sformatf("rsp_readdata_d%0d", d));
    @(negedge clk);
    chk(32'(obs_rv[d]), 32'd0, $sformatf("rsp_one_cycle_d%0d", d));
    chk(32'(wr_cnt[d] - w0), wr ? 32'd1 : 32'd0, $sformatf("wr_strobe_cycles_d%0d", d));
    chk(32'(rd_cnt[d] - r0), wr ? 32'd0 : 32'd1, $sformatf("rd_strobe_cycles_d%0d", d));
    chk(32'(rsp_cnt[d] - s0), 32'd1, $sformatf("rsp_count_d%0d", d));
    if (wr) begin
      chk(32'(wr_addr_s[d]), 32'(a), $sformatf("wr_strobe_addr_d%0d", d));
      chk(wr_data_s[d], wd, $sformatf("wr_strobe_data_d%0d", d));
    end else begin
      chk(32'(rd_addr_s[d]), 32'(a), $sformatf("rd_strobe_addr_d%0d", d));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0, r0, k, n, prev, acc;
    bit pend, prev_wr;

    for (int d = 0; d < NDUT; d++) begin
      cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0;
      cmd_address[d] = 2'd0; cmd_writedata[d] = 32'h0;
    end
    clear_model();

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk_reset_outs(d, "por");
    reset_n = 1'b1;
    #1;
    chk(32'(obs_ready[0]), 32'd0, "ready_before_first_edge");
    @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      chk(32'(obs_ready[d]), 32'd1, $sformatf("ready_first_edge_d%0d", d));

    // PIO write then read-back, direction register read, hold across write
    do_txn(0, 1'b1, 2'd0, 32'h1);
    chk(out_port[0], 32'h1, "out_port_after_write");
    do_txn(0, 1'b0, 2'd0, 32'h0);
    do_txn(0, 1'b1, 2'd2, $urandom);
    do_txn(0, 1'b0, 2'd1, 32'h0);

    // Latency sweep against the delayed-readdata responder
    for (int d = 2; d < NDUT; d++) begin
      do_txn(d, 1'b1, 2'd3, $urandom);
      do_txn(d, 1'b0, 2'd3, 32'h0);
    end

    // Random traffic on all instances
    for (int rep = 0; rep < 24; rep++) begin
      int d;
      d = int'($urandom_range(0, NDUT - 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(d, 1'($urandom), 2'($urandom_range(0, 3)), $urandom);
    end

    // Continuous cmd_valid, alternating write/read on READ_LATENCY=2
    s0 = rsp_cnt[1]; k = 0; n = 0; prev = -1; pend = 1'b0; prev_wr = 1'b0;
    cmd_valid[1] = 1'b1; cmd_write[1] = 1'b1;
    cmd_address[1] = 2'd0; cmd_writedata[1] = $urandom;
    while (k < 6 && n < 100) begin
      if (obs_ready[1] === 1'b1) begin
        if (prev >= 0) chk(32'(cyc - prev), prev_wr ? 32'd3 : 32'd5, $sformatf("b2b_spacing_%0d", k));
        if (cmd_write[1]) begin
          if (cmd_address[1] != 2'd1) mem_m[1][cmd_address[1]] = cmd_writedata[1];
        end else begin
          last_rd[1] = (cmd_address[1] == 2'd1) ? 32'h0 : mem_m[1][cmd_address[1]];
        end
        prev = cyc; prev_wr = cmd_write[1]; k++; pend = 1'b1;
      end
      @(negedge clk); n++;
      if (pend) begin
        cmd_write[1] = ~cmd_write[1];
        cmd_address[1] = 2'($urandom_range(0, 3));
        cmd_writedata[1] = $urandom;
        pend = 1'b0;
      end
    end
    cmd_valid[1] = 1'b0;
    chk(32'(k), 32'd6, "b2b_accepts");
    repeat (12) @(negedge clk);
    chk(32'(rsp_cnt[1] - s0), 32'd6, "b2b_one_rsp_per_accept");
    chk(obs_rd[1], last_rd[1], "b2b_last_readdata");

    // Reset in RWAIT on READ_LATENCY=7
    do_txn(3, 1'b1, 2'd0, 32'h5A5A_1234);
    cmd_valid[3] = 1'b1; cmd_write[3] = 1'b0; cmd_address[3] = 2'd0;
    n = 0;
    while (obs_ready[3] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    acc = cyc;
    @(negedge clk);
    cmd_valid[3] = 1'b0;
    @(negedge clk);
    chk(32'(cyc - acc), 32'd2, "rwait_reached");
    s0 = rsp_cnt[3];
    reset_n = 1'b0;
    clear_model();
    #1;
    chk_reset_outs(3, "midrst");
    r0 = rd_cnt[3];
    repeat (3) @(negedge clk);
    chk(32'(rsp_cnt[3] - s0), 32'd0, "midrst_no_rsp_in_reset");
    reset_n = 1'b1;
    #1;
    chk(32'(obs_ready[3]), 32'd0, "midrst_ready_before_edge");
    @(posedge clk);
    #1;
    chk(32'(obs_ready[3]), 32'd1, "midrst_ready_one_edge");
    repeat (12) @(negedge clk);
    chk(32'(rsp_cnt[3] - s0), 32'd0, "midrst_no_rsp_after");
    chk(32'(rd_cnt[3] - r0), 32'd0, "midrst_no_replay");
    do_txn(3, 1'b0, 2'd0, 32'h0);

    for (int d = 0; d < NDUT; d++)
      chk(32'(both_cnt[d]), 32'd0, $sformatf("no_dual_strobe_d%0d", d));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
